// File: rtl/diag_block_engine.sv
// Diagnostics command engine between the SPI slave byte port and the shadow RAM:
// HALT/RESUME/config reply, ranged read/write with group parity, retransmit and CRC32.
module diag_block_engine #(
    parameter int ADDR_WIDTH   = 16,
    parameter int PARITY_GROUP = 8,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    fpga_clk,
    input  logic                    fpga_reset,
    input  logic                    rx_dv,
    input  logic [7:0]              rx_byte,
    output logic                    tx_dv,
    output logic [7:0]              tx_byte,
    output logic                    halt,
    output logic [ADDR_WIDTH-1:0]   address,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic                    we,
    output logic                    cs,
    input  logic [CONFIG_WIDTH-1:0] configuration,
    output logic                    busy,
    output logic                    error
);
    localparam int AB = ADDR_WIDTH / 8;
    localparam int HW = 2 * ADDR_WIDTH;
    localparam int GW = $clog2(PARITY_GROUP);

    typedef enum logic [4:0] {
        ST_STARTUP, ST_RUN, ST_CFG_WAIT, ST_HALTED, ST_HDR,
        ST_DUMMY, ST_RD_WAIT, ST_RD_PREP, ST_RD_SEND, ST_PAR_WAIT, ST_PAR_SEND, ST_REPLY_WAIT,
        ST_WR_IDLE, ST_WR_STB, ST_WR_ADV, ST_WR_TAIL, ST_CRC_LOAD, ST_CRC_WAIT
    } state_t;

    state_t                  state, state_next;
    logic [CONFIG_WIDTH-1:0] cfg;
    logic                    op_write;
    logic [HW-9:0]           hdr_sr;
    logic [2:0]              hdr_cnt;
    logic [ADDR_WIDTH:0]     remaining, grp_rem;
    logic [ADDR_WIDTH-1:0]   grp_start;
    logic [31:0]             crc, crc_snap;
    logic [GW-1:0]           grp_cnt;
    logic [7:0]              parity;
    logic [2:0]              crc_idx;
    logic                    skid_valid;
    logic [7:0]              skid_byte;

    logic [HW-1:0]           hdr_full_s;
    logic [ADDR_WIDTH:0]     len_s;
    logic                    hdr_last_s, grp_last_s, wr_take_s;
    logic [7:0]              wr_byte_s;

    // Reflected CRC32 (0xEDB88320), one byte per call, no final XOR
    function automatic logic [31:0] crc_step(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // Header assembly, group bookkeeping and write-byte source selection
    always_comb begin
        hdr_full_s = {hdr_sr, rx_byte};
        hdr_last_s = rx_dv && (hdr_cnt == 3'(2 * AB - 1));
        if (hdr_full_s[ADDR_WIDTH-1:0] == '0) begin
            len_s = {1'b1, {ADDR_WIDTH{1'b0}}};
        end else begin
            len_s = {1'b0, hdr_full_s[ADDR_WIDTH-1:0]};
        end
        grp_last_s = (grp_cnt == GW'(PARITY_GROUP - 1)) || (remaining == (ADDR_WIDTH + 1)'(1));
        wr_take_s  = skid_valid || rx_dv;
        wr_byte_s  = skid_valid ? skid_byte : rx_byte;
    end

    // State register
    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset) begin
            state <= ST_STARTUP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_STARTUP:    state_next = ST_RUN;
            ST_RUN: begin
                if (rx_dv && rx_byte == 8'hAA) begin
                    state_next = ST_HALTED;
                end else if (rx_dv && rx_byte == 8'h77) begin
                    state_next = ST_CFG_WAIT;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_CFG_WAIT:   state_next = rx_dv ? ST_RUN : ST_CFG_WAIT;
            ST_HALTED: begin
                if (rx_dv) begin
                    case (rx_byte)
                        8'h55:        state_next = ST_RUN;
                        8'h66, 8'h99: state_next = ST_HDR;
                        default:      state_next = ST_HALTED;
                    endcase
                end else begin
                    state_next = ST_HALTED;
                end
            end
            ST_HDR:        state_next = hdr_last_s ? (op_write ? ST_WR_IDLE : ST_DUMMY) : ST_HDR;
            ST_DUMMY:      state_next = ST_RD_WAIT;
            ST_RD_WAIT:    state_next = rx_dv ? ST_RD_SEND : ST_RD_WAIT;
            ST_RD_PREP:    state_next = ST_RD_SEND;
            ST_RD_SEND:    state_next = grp_last_s ? ST_PAR_WAIT : ST_RD_WAIT;
            ST_PAR_WAIT:   state_next = rx_dv ? ST_PAR_SEND : ST_PAR_WAIT;
            ST_PAR_SEND:   state_next = ST_REPLY_WAIT;
            ST_REPLY_WAIT: begin
                if (rx_dv) begin
                    state_next = (rx_byte != 8'h22 && remaining == '0) ? ST_CRC_LOAD : ST_RD_PREP;
                end else begin
                    state_next = ST_REPLY_WAIT;
                end
            end
            ST_WR_IDLE:    state_next = wr_take_s ? ST_WR_STB : ST_WR_IDLE;
            ST_WR_STB:     state_next = ST_WR_ADV;
            ST_WR_ADV:     state_next = (remaining == (ADDR_WIDTH + 1)'(1)) ? ST_WR_TAIL : ST_WR_IDLE;
            ST_WR_TAIL:    state_next = wr_take_s ? ST_CRC_LOAD : ST_WR_TAIL;
            ST_CRC_LOAD:   state_next = ST_CRC_WAIT;
            ST_CRC_WAIT:   state_next = rx_dv ? ((crc_idx == 3'd4) ? ST_HALTED : ST_CRC_LOAD) : ST_CRC_WAIT;
            default:       state_next = ST_STARTUP;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset) begin
            tx_dv <= 1'b0; tx_byte <= 8'h00; halt <= 1'b0; address <= '0;
            data_out <= 8'h00; we <= 1'b0; cs <= 1'b0; busy <= 1'b0; error <= 1'b0;
            cfg <= '0; op_write <= 1'b0; hdr_sr <= '0; hdr_cnt <= 3'd0;
            remaining <= '0; grp_rem <= '0; grp_start <= '0; crc <= 32'h0; crc_snap <= 32'h0;
            grp_cnt <= '0; parity <= 8'h00; crc_idx <= 3'd0;
        end else begin
            tx_dv <= 1'b0;
            we    <= 1'b0;
            busy  <= (state_next != ST_RUN) && (state_next != ST_HALTED);
            case (state)
                ST_STARTUP: cfg <= configuration;
                ST_RUN: begin
                    if (rx_dv && rx_byte == 8'hAA) begin
                        halt <= 1'b1;
                    end else if (rx_dv && rx_byte == 8'h77) begin
                        tx_byte <= 8'(cfg);
                        tx_dv   <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (rx_dv) begin
                        case (rx_byte)
                            8'h55:   begin halt <= 1'b0; error <= 1'b0; end
                            8'h66:   begin op_write <= 1'b0; hdr_cnt <= 3'd0; end
                            8'h99:   begin op_write <= 1'b1; hdr_cnt <= 3'd0; end
                            default: error <= 1'b1;
                        endcase
                    end
                end
                ST_HDR: begin
                    if (rx_dv) begin
                        hdr_sr  <= hdr_full_s[HW-9:0];
                        hdr_cnt <= hdr_cnt + 3'd1;
                    end
                    if (hdr_last_s) begin
                        cs        <= 1'b1;
                        address   <= hdr_full_s[HW-1:ADDR_WIDTH];
                        grp_start <= hdr_full_s[HW-1:ADDR_WIDTH];
                        remaining <= len_s;
                        grp_rem   <= len_s;
                        crc       <= 32'h0;
                        crc_snap  <= 32'h0;
                        grp_cnt   <= '0;
                        parity    <= 8'h00;
                        crc_idx   <= 3'd0;
                    end
                end
                ST_DUMMY: begin
                    tx_byte <= 8'h00;
                    tx_dv   <= 1'b1;
                end
                ST_RD_SEND: begin
                    tx_byte   <= data_in;
                    tx_dv     <= 1'b1;
                    crc       <= crc_step(crc, data_in);
                    parity    <= parity ^ data_in;
                    address   <= address + ADDR_WIDTH'(1);
                    remaining <= remaining - (ADDR_WIDTH + 1)'(1);
                    grp_cnt   <= grp_last_s ? '0 : grp_cnt + GW'(1);
                end
                ST_PAR_SEND: begin
                    tx_byte <= parity;
                    tx_dv   <= 1'b1;
                end
                ST_REPLY_WAIT: begin
                    if (rx_dv) begin
                        parity <= 8'h00;
                        // 0x22 rolls the whole group back, including its CRC contribution
                        if (rx_byte == 8'h22) begin
                            address   <= grp_start;
                            crc       <= crc_snap;
                            remaining <= grp_rem;
                        end else begin
                            grp_start <= address;
                            crc_snap  <= crc;
                            grp_rem   <= remaining;
                        end
                    end
                end
                ST_WR_IDLE: begin
                    if (wr_take_s) begin
                        data_out <= wr_byte_s;
                        tx_byte  <= wr_byte_s;
                        tx_dv    <= 1'b1;
                        crc      <= crc_step(crc, wr_byte_s);
                    end
                end
                ST_WR_STB: we <= 1'b1;
                ST_WR_ADV: begin
                    address   <= address + ADDR_WIDTH'(1);
                    remaining <= remaining - (ADDR_WIDTH + 1)'(1);
                end
                ST_CRC_LOAD: begin
                    case (crc_idx)
                        3'd0:    tx_byte <= crc[31:24];
                        3'd1:    tx_byte <= crc[23:16];
                        3'd2:    tx_byte <= crc[15:8];
                        default: tx_byte <= crc[7:0];
                    endcase
                    tx_dv   <= 1'b1;
                    crc_idx <= crc_idx + 3'd1;
                end
                ST_CRC_WAIT: begin
                    if (rx_dv && crc_idx == 3'd4) begin
                        cs <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-deep skid: holds a byte that lands while a write cycle is still in progress
    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset) begin
            skid_valid <= 1'b0;
            skid_byte  <= 8'h00;
        end else if (state == ST_WR_IDLE || state == ST_WR_TAIL) begin
            skid_valid <= skid_valid && rx_dv;
            if (skid_valid && rx_dv) begin
                skid_byte <= rx_byte;
            end
        end else if (state == ST_WR_STB || state == ST_WR_ADV) begin
            if (rx_dv) begin
                skid_valid <= 1'b1;
                skid_byte  <= rx_byte;
            end
        end else begin
            skid_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_diag_block_engine.sv
// Bench for diag_block_engine: control-command vector table, tx-stream scoreboard for
// ranged reads/writes (16-bit build) and a full-space read on an 8-bit-address build.
module tb_diag_block_engine;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        sel = 1'b0;
    logic [3:0]  cfg_in = 4'h0;

    logic        tx_dv_a, halt_a, we_a, cs_a, busy_a, error_a;
    logic [7:0]  tx_byte_a, data_out_a, data_in_a;
    logic [15:0] addr_a;
    logic        tx_dv_b, halt_b, we_b, cs_b, busy_b, error_b;
    logic [7:0]  tx_byte_b, data_out_b, data_in_b;
    logic [7:0]  addr_b;

    logic [7:0]  mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h00;

    logic [7:0]  exp_q [$];
    logic [7:0]  host_q [$];
    logic [31:0] crc_tab [0:255];
    int          total = 0;
    int          bad = 0;
    int          we_cnt = 0;
    logic        we_prev = 1'b0;

    typedef struct {
        logic [7:0] cmd;
        logic       halt;
        logic       err;
    } vec_t;
    vec_t vt [8];

    always #5 clk = ~clk;

    diag_block_engine #(.ADDR_WIDTH(16), .PARITY_GROUP(8), .CONFIG_WIDTH(4)) dut_a (
        .fpga_clk(clk), .fpga_reset(rst_l), .rx_dv(rx_dv & ~sel), .rx_byte(rx_byte),
        .tx_dv(tx_dv_a), .tx_byte(tx_byte_a), .halt(halt_a), .address(addr_a),
        .data_in(data_in_a), .data_out(data_out_a), .we(we_a), .cs(cs_a),
        .configuration(cfg_in), .busy(busy_a), .error(error_a));

    diag_block_engine #(.ADDR_WIDTH(8), .PARITY_GROUP(8), .CONFIG_WIDTH(4)) dut_b (
        .fpga_clk(clk), .fpga_reset(rst_l), .rx_dv(rx_dv & sel), .rx_byte(rx_byte),
        .tx_dv(tx_dv_b), .tx_byte(tx_byte_b), .halt(halt_b), .address(addr_b),
        .data_in(data_in_b), .data_out(data_out_b), .we(we_b), .cs(cs_b),
        .configuration(cfg_in), .busy(busy_b), .error(error_b));

    // Shadow RAM models: synchronous read, data valid one cycle after the address
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (we_a) mem[addr_a] <= data_out_a;
        data_in_a <= mem[addr_a];
        data_in_b <= 8'(addr_b * 8'd7 + 8'd3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        return crc_tab[c[7:0] ^ d] ^ (c >> 8);
    endfunction

    // Scoreboard consumer: every tx_dv pops one expected byte; we must be 1-cycle pulses
    always @(negedge clk) begin : mon
        logic       tv;
        logic [7:0] tbv;
        tv  = sel ? tx_dv_b : tx_dv_a;
        tbv = sel ? tx_byte_b : tx_byte_a;
        if (tv) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got %0h expected none", tbv);
            end else begin
                chk("tx_byte", 32'(tbv), 32'(exp_q.pop_front()));
            end
        end
        if (we_a) begin
            we_cnt++;
            chk("we_width", 32'(we_prev), 32'd0);
        end
        we_prev = we_a;
    end

    task automatic xchg(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic ram_put(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic push_crc(input logic [31:0] c);
        exp_q.push_back(c[31:24]); exp_q.push_back(c[23:16]);
        exp_q.push_back(c[15:8]);  exp_q.push_back(c[7:0]);
    endtask

    // Ranged read: builds the expected tx stream and the host replies, then runs it
    task automatic run_read(input logic is_b, input logic [15:0] start, input logic [15:0] len_hdr,
                            input int retry_grp);
        int          n, off, g, cnt;
        logic [31:0] crc, gcrc;
        logic [7:0]  par, d;
        logic [15:0] a;
        n = (len_hdr != 16'h0) ? int'(len_hdr) : (is_b ? 256 : 65536);
        crc = 32'h0; off = 0; g = 0;
        host_q.delete();
        exp_q.push_back(8'h00); host_q.push_back(8'h00);
        while (off < n) begin
            cnt  = (n - off < 8) ? (n - off) : 8;
            gcrc = crc;
            for (int pass = 0; pass < ((g == retry_grp) ? 2 : 1); pass++) begin
                crc = gcrc; par = 8'h00;
                for (int k = 0; k < cnt; k++) begin
                    a = start + 16'(off + k);
                    d = is_b ? 8'(a[7:0] * 8'd7 + 8'd3) : mem[a];
                    exp_q.push_back(d); host_q.push_back(8'h00);
                    crc = crc_upd(crc, d);
                    par = par ^ d;
                end
                exp_q.push_back(par);
                host_q.push_back((pass == 0 && g == retry_grp) ? 8'h22 : 8'h5A);
            end
            off += cnt; g++;
        end
        for (int k = 0; k < 4; k++) host_q.push_back(8'h00);
        push_crc(crc);
        xchg(8'h66);
        if (is_b) begin
            xchg(start[7:0]); xchg(len_hdr[7:0]);
        end else begin
            xchg(start[15:8]); xchg(start[7:0]); xchg(len_hdr[15:8]); xchg(len_hdr[7:0]);
        end
        chk("rd_busy", 32'(is_b ? busy_b : busy_a), 32'd1);
        while (host_q.size() > 1) xchg(host_q.pop_front());
        chk("rd_cs_before_end", 32'(is_b ? cs_b : cs_a), 32'd1);
        xchg(host_q.pop_front());
        chk("rd_cs_after_end", 32'(is_b ? cs_b : cs_a), 32'd0);
        chk("rd_halt_after_end", 32'(is_b ? halt_b : halt_a), 32'd1);
        chk("rd_busy_after_end", 32'(is_b ? busy_b : busy_a), 32'd0);
        chk("rd_sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] c;
        int          w0;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[n] = c;
        end
        vt[0] = '{8'h12, 1'b0, 1'b0};
        vt[1] = '{8'hAA, 1'b1, 1'b0};
        vt[2] = '{8'h13, 1'b1, 1'b1};
        vt[3] = '{8'hAA, 1'b1, 1'b1};
        vt[4] = '{8'h55, 1'b0, 1'b0};
        vt[5] = '{8'h13, 1'b0, 1'b0};
        vt[6] = '{8'hAA, 1'b1, 1'b0};
        vt[7] = '{8'h55, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_dv", 32'(tx_dv_a), 32'd0);
        chk("rst_halt", 32'(halt_a), 32'd0);
        chk("rst_cs", 32'(cs_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_error", 32'(error_a), 32'd0);
        chk("rst_address", 32'(addr_a), 32'd0);
        cfg_in = 4'hA;
        rst_l  = 1'b1;
        repeat (3) @(posedge clk);

        exp_q.push_back(8'h0A);
        xchg(8'h77);
        chk("cfg_busy", 32'(busy_a), 32'd1);
        xchg(8'h00);
        chk("cfg_back_run", 32'(busy_a), 32'd0);

        for (int i = 0; i < 8; i++) begin
            xchg(vt[i].cmd);
            chk("ctl_halt", 32'(halt_a), 32'(vt[i].halt));
            chk("ctl_error", 32'(error_a), 32'(vt[i].err));
            chk("ctl_busy", 32'(busy_a), 32'd0);
        end

        for (int i = 0; i < 16; i++) ram_put(16'h1000 + 16'(i), 8'(i));
        xchg(8'hAA);
        run_read(1'b0, 16'h1000, 16'h0010, -1);
        run_read(1'b0, 16'h1000, 16'h0010, 0);
        run_read(1'b0, 16'h1003, 16'h0005, -1);

        w0 = we_cnt;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        c = crc_upd(crc_upd(crc_upd(crc_upd(32'h0, 8'h11), 8'h22), 8'h33), 8'h44);
        push_crc(c);
        xchg(8'h99); xchg(8'hFF); xchg(8'hFE); xchg(8'h00); xchg(8'h04);
        xchg(8'h11); xchg(8'h22); xchg(8'h33); xchg(8'h44);
        for (int k = 0; k < 5; k++) xchg(8'h00);
        chk("wr_we_count", 32'(we_cnt - w0), 32'd4);
        chk("wr_mem_fffe", 32'(mem[16'hFFFE]), 32'h11);
        chk("wr_mem_ffff", 32'(mem[16'hFFFF]), 32'h22);
        chk("wr_mem_0000", 32'(mem[16'h0000]), 32'h33);
        chk("wr_mem_0001", 32'(mem[16'h0001]), 32'h44);
        chk("wr_cs_end", 32'(cs_a), 32'd0);
        chk("wr_sb_drained", 32'(exp_q.size()), 32'd0);
        xchg(8'h55);

        sel = 1'b1;
        xchg(8'hAA);
        run_read(1'b1, 16'h0000, 16'h0000, -1);
        xchg(8'h55);
        sel = 1'b0;

        for (int i = 0; i < 4; i++) ram_put(16'h0020 + 16'(i), 8'hEE);
        xchg(8'hAA);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
        xchg(8'h99); xchg(8'h00); xchg(8'h20); xchg(8'h00); xchg(8'h04);
        xchg(8'hA1);
        @(posedge clk); #1;
        rx_byte = 8'hB2; rx_dv = 1'b1;
        @(posedge clk); #1;
        rx_dv = 1'b0; rst_l = 1'b0;
        w0 = we_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_cs", 32'(cs_a), 32'd0);
        chk("mid_rst_halt", 32'(halt_a), 32'd0);
        chk("mid_rst_we", 32'(we_a), 32'd0);
        rst_l = 1'b1;
        xchg(8'hC3);
        xchg(8'hD4);
        chk("mid_rst_no_we", 32'(we_cnt - w0), 32'd0);
        chk("mid_rst_mem20", 32'(mem[16'h0020]), 32'hA1);
        chk("mid_rst_mem21", 32'(mem[16'h0021]), 32'hEE);
        chk("mid_rst_mem22", 32'(mem[16'h0022]), 32'hEE);
        xchg(8'hAA);
        xchg(8'h13);
        chk("err_set", 32'(error_a), 32'd1);
        xchg(8'h55);
        chk("err_clear", 32'(error_a), 32'd0);
        chk("err_halt_clear", 32'(halt_a), 32'd0);
        chk("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
